// File: rtl/bit_sync_filter_if.sv
// Level bus between asynchronous sources and the bit_sync_filter block.
// The master drives the raw levels; the slave returns the filtered levels and edge pulses.
interface bit_sync_filter_if #(
  parameter int BUS_WIDTH = 1
);
  logic [BUS_WIDTH-1:0] async_lvl;
  logic [BUS_WIDTH-1:0] sync_lvl;
  logic [BUS_WIDTH-1:0] rise_pls;
  logic [BUS_WIDTH-1:0] fall_pls;

  modport master (
    output async_lvl,
    input  sync_lvl,
    input  rise_pls,
    input  fall_pls
  );

  modport slave (
    input  async_lvl,
    output sync_lvl,
    output rise_pls,
    output fall_pls
  );
endinterface

// File: rtl/bit_sync_filter.sv
// Per-channel multi-flop synchronizer followed by a persistence filter and optional edge pulses.
// Define BIT_SYNC_EDGE_EN to build the RISE/FALL detectors; otherwise those outputs are tied low.
module bit_sync_filter #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 1,
  parameter int FILT_CNT   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_sync_filter_if.slave   bus_if
);

  localparam int CNT_W = $clog2(FILT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic [BUS_WIDTH-1:0] sync_q;

`ifdef BIT_SYNC_EDGE_EN
  logic [BUS_WIDTH-1:0] sync_d;
`endif

  for (genvar ch = 0; ch < BUS_WIDTH; ch++) begin : g_chan
    logic [NUM_STAGES-1:0] chain_q;
    logic                  s_last;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  lvl_q;
    logic                  lvl_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chain_q <= '0;
      end else begin
        chain_q <= {chain_q[NUM_STAGES-2:0], bus_if.async_lvl[ch]};
      end
    end

    assign s_last = chain_q[NUM_STAGES-1];

    // A differing level must be seen FILT_CNT times in a row; any agreement restarts the count.
    always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (s_last == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        lvl_d = s_last;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign sync_q[ch] = lvl_q;

`ifdef BIT_SYNC_EDGE_EN
    assign sync_d[ch] = lvl_d;
`endif
  end

  assign bus_if.sync_lvl = sync_q;

`ifdef BIT_SYNC_EDGE_EN
  logic [BUS_WIDTH-1:0] rise_q;
  logic [BUS_WIDTH-1:0] fall_q;
  logic [BUS_WIDTH-1:0] rise_d;
  logic [BUS_WIDTH-1:0] fall_d;

  // Pulses are registered alongside the SYNC load so they line up with the new level.
  assign rise_d = sync_d & ~sync_q;
  assign fall_d = ~sync_d & sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus_if.rise_pls = rise_q;
  assign bus_if.fall_pls = fall_q;
`else
  assign bus_if.rise_pls = '0;
  assign bus_if.fall_pls = '0;
`endif

endmodule

// File: tb/tb_bit_sync_filter.sv
// Directed bench for bit_sync_filter with NUM_STAGES=2, BUS_WIDTH=4, FILT_CNT=3.
// Works with or without BIT_SYNC_EDGE_EN; expected pulses follow the macro.
module tb_bit_sync_filter;

  localparam int BW = 4;

`ifdef BIT_SYNC_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bit_sync_filter_if #(.BUS_WIDTH(BW)) bus_if ();

  bit_sync_filter #(
    .NUM_STAGES(2),
    .BUS_WIDTH (BW),
    .FILT_CNT  (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] edge_mask(input logic [BW-1:0] m);
    return EDGE_EN ? m : '0;
  endfunction

  task automatic test_reset();
    logic [BW-1:0] es, er;
    rst_n = 1'b1;
    bus_if.async_lvl = 4'hF;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.sync_lvl !== 4'h0 || bus_if.rise_pls !== 4'h0 || bus_if.fall_pls !== 4'h0) begin
      errors++;
      $display("FAIL reset_async: sync=%h rise=%h fall=%h expected all 0",
               bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls);
    end
    tick();
    tick();
    checks++;
    if (bus_if.sync_lvl !== 4'h0 || bus_if.rise_pls !== 4'h0 || bus_if.fall_pls !== 4'h0) begin
      errors++;
      $display("FAIL reset_held: sync=%h rise=%h fall=%h expected all 0",
               bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      es = (e >= 5) ? 4'hF : 4'h0;
      er = (e == 5) ? edge_mask(4'hF) : 4'h0;
      checks++;
      if (bus_if.sync_lvl !== es || bus_if.rise_pls !== er || bus_if.fall_pls !== 4'h0) begin
        errors++;
        $display("FAIL reset_release edge %0d: sync=%h rise=%h fall=%h expected sync=%h rise=%h fall=0",
                 e, bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls, es, er);
      end
    end
  endtask

  task automatic test_fall_all();
    logic [BW-1:0] es, ef;
    bus_if.async_lvl = 4'h0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      es = (e >= 5) ? 4'h0 : 4'hF;
      ef = (e == 5) ? edge_mask(4'hF) : 4'h0;
      checks++;
      if (bus_if.sync_lvl !== es || bus_if.fall_pls !== ef || bus_if.rise_pls !== 4'h0) begin
        errors++;
        $display("FAIL fall_all edge %0d: sync=%h rise=%h fall=%h expected sync=%h rise=0 fall=%h",
                 e, bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls, es, ef);
      end
    end
  endtask

  task automatic test_single_rise();
    logic [BW-1:0] es, er;
    bus_if.async_lvl = 4'h1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      es = (e >= 5) ? 4'h1 : 4'h0;
      er = (e == 5) ? edge_mask(4'h1) : 4'h0;
      checks++;
      if (bus_if.sync_lvl !== es || bus_if.rise_pls !== er || bus_if.fall_pls !== 4'h0) begin
        errors++;
        $display("FAIL single_rise edge %0d: sync=%h rise=%h fall=%h expected sync=%h rise=%h fall=0",
                 e, bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls, es, er);
      end
    end
  endtask

  // Two-cycle pulse is rejected, one low cycle restarts the count, then a held level passes.
  task automatic test_glitch();
    logic [BW-1:0] es, er;
    for (int e = 1; e <= 10; e++) begin
      bus_if.async_lvl = (e == 3) ? 4'h1 : 4'h3;
      tick();
      es = (e >= 8) ? 4'h3 : 4'h1;
      er = (e == 8) ? edge_mask(4'h2) : 4'h0;
      checks++;
      if (bus_if.sync_lvl !== es || bus_if.rise_pls !== er || bus_if.fall_pls !== 4'h0) begin
        errors++;
        $display("FAIL glitch edge %0d: sync=%h rise=%h fall=%h expected sync=%h rise=%h fall=0",
                 e, bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls, es, er);
      end
    end
  endtask

  task automatic test_multi_channel();
    logic [BW-1:0] es, er, ef;
    bus_if.async_lvl = 4'hC;
    for (int e = 1; e <= 6; e++) begin
      tick();
      es = (e >= 5) ? 4'hC : 4'h3;
      er = (e == 5) ? edge_mask(4'hC) : 4'h0;
      ef = (e == 5) ? edge_mask(4'h3) : 4'h0;
      checks++;
      if (bus_if.sync_lvl !== es || bus_if.rise_pls !== er || bus_if.fall_pls !== ef) begin
        errors++;
        $display("FAIL multi_channel edge %0d: sync=%h rise=%h fall=%h expected sync=%h rise=%h fall=%h",
                 e, bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls, es, er, ef);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] es, er;
    bus_if.async_lvl = 4'hB;
    for (int e = 1; e <= 6; e++) tick();
    checks++;
    if (bus_if.sync_lvl !== 4'hB) begin
      errors++;
      $display("FAIL mid_settle: sync=%h expected b", bus_if.sync_lvl);
    end
    bus_if.async_lvl = 4'hF;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (bus_if.sync_lvl !== 4'hB || bus_if.rise_pls !== 4'h0) begin
        errors++;
        $display("FAIL mid_prefilter edge %0d: sync=%h rise=%h expected sync=b rise=0",
                 e, bus_if.sync_lvl, bus_if.rise_pls);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.sync_lvl !== 4'h0 || bus_if.rise_pls !== 4'h0 || bus_if.fall_pls !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: sync=%h rise=%h fall=%h expected all 0",
               bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls);
    end
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      es = (e >= 5) ? 4'hF : 4'h0;
      er = (e == 5) ? edge_mask(4'hF) : 4'h0;
      checks++;
      if (bus_if.sync_lvl !== es || bus_if.rise_pls !== er || bus_if.fall_pls !== 4'h0) begin
        errors++;
        $display("FAIL mid_reset_relatch edge %0d: sync=%h rise=%h fall=%h expected sync=%h rise=%h fall=0",
                 e, bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls, es, er);
      end
    end
  endtask

  task automatic test_release_zero();
    bus_if.async_lvl = 4'h0;
    for (int e = 1; e <= 6; e++) tick();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (bus_if.sync_lvl !== 4'h0 || bus_if.rise_pls !== 4'h0 || bus_if.fall_pls !== 4'h0) begin
        errors++;
        $display("FAIL release_zero edge %0d: sync=%h rise=%h fall=%h expected all 0",
                 e, bus_if.sync_lvl, bus_if.rise_pls, bus_if.fall_pls);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall_all();
    test_single_rise();
    test_glitch();
    test_multi_channel();
    test_reset_mid();
    test_release_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/bit_sync_filter.md
BIT_SYNC_FILTER -- requirements
Module: bit_sync_filter

Interface
REQ-001 Parameter NUM_STAGES, default 2, number of synchronizer flops per channel; legal range 2 or more.
REQ-002 Parameter BUS_WIDTH, default 1, number of independent channels; legal range 1 or more.
REQ-003 Parameter FILT_CNT, default 1, number of consecutive cycles a new synchronized level must persist before it is accepted; legal range 1 or more.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 ASYNC  input  BUS_WIDTH  asynchronous level inputs, one bit per channel.
REQ-007 SYNC  output  BUS_WIDTH  synchronized, glitch-filtered level, registered.
REQ-008 RISE  output  BUS_WIDTH  one-cycle pulse when SYNC[i] goes 0->1, registered.
REQ-009 FALL  output  BUS_WIDTH  one-cycle pulse when SYNC[i] goes 1->0, registered.

Function
REQ-010 Each channel i shall have an independent shift chain of NUM_STAGES flops; stage 0 captures ASYNC[i], and the last stage (s_i) feeds the filter.
REQ-011 Each channel shall have a stability counter of width clog2(FILT_CNT+1), saturating at no value above FILT_CNT-1.
REQ-012 The counter shall clear on any edge where s_i equals SYNC[i].
REQ-013 The counter shall increment on any edge where s_i differs from SYNC[i] and the counter is below FILT_CNT-1.
REQ-014 On an edge where s_i differs from SYNC[i] and the counter equals FILT_CNT-1, SYNC[i] shall load s_i and the counter shall clear.
REQ-015 Latency: for a level captured by stage 0 on edge k and held, SYNC[i] shall change on edge k+NUM_STAGES+FILT_CNT-1.
REQ-016 A level at s_i lasting fewer than FILT_CNT consecutive cycles shall not change SYNC[i], and the counter shall restart from 0 when s_i returns to SYNC[i].
REQ-017 With FILT_CNT=1, SYNC[i] shall follow s_i with exactly one cycle of delay, so no glitch filtering occurs.
REQ-018 RISE[i] shall be 1 for exactly the one cycle following the edge on which SYNC[i] loads 1 from 0; it shall be 0 in every other cycle.
REQ-019 FALL[i] shall be 1 for exactly the one cycle following the edge on which SYNC[i] loads 0 from 1; it shall be 0 in every other cycle.
REQ-020 RISE[i] and FALL[i] shall never be 1 in the same cycle.
REQ-021 Channels shall not interact; simultaneous transitions on any subset of channels shall produce independent, simultaneous SYNC, RISE and FALL updates.
REQ-022 Multi-bit coherence across channels is not guaranteed; ASYNC bits shall be treated as unrelated signals.

Reset
REQ-023 While RST is 0, all synchronizer flops, counters, SYNC, RISE and FALL shall be 0, without waiting for a CLK edge.
REQ-024 Reset asserted mid-filter shall discard partial counts; after release, a held input shall again require the full latency of REQ-015.
REQ-025 No RISE pulse shall be produced by reset release itself when ASYNC is 0.

Configuration
REQ-026 Macro BIT_SYNC_EDGE_EN defined: the RISE/FALL edge-detect logic is compiled in as in REQ-018 to REQ-020.
REQ-027 Macro BIT_SYNC_EDGE_EN undefined: the RISE and FALL ports remain present and are tied to constant 0, no edge-detect flops are built, and SYNC behaviour is unchanged.

Verification (NUM_STAGES=2, BUS_WIDTH=4, FILT_CNT=3, macro defined unless noted)
REQ-028 Assert RST=0 with ASYNC=4'hF, then release -> SYNC=RISE=FALL=4'h0 during reset; RISE[3:0] pulses once when SYNC reaches 4'hF, 5 edges after the first capture.
REQ-029 ASYNC[0] 0->1 before edge 1, then held -> SYNC[0]=1 after edge 5; RISE[0]=1 for exactly the cycle after edge 5; other bits stay 0.
REQ-030 ASYNC[1] high for 2 cycles, then low -> SYNC[1] stays 0, and RISE[1] and FALL[1] stay 0 throughout.
REQ-031 ASYNC 4'hF->4'h0 on all channels with SYNC=4'hF -> SYNC=4'h0 after 5 edges; FALL=4'hF for one cycle; RISE stays 4'h0.
REQ-032 ASYNC[2] 0->1, then RST pulsed low after edge 3 -> SYNC[2] cleared immediately; after release, SYNC[2]=1 only after 5 further edges.
REQ-033 Repeat REQ-029 and REQ-031 with BIT_SYNC_EDGE_EN undefined -> SYNC timing identical; RISE=FALL=4'h0 at all times.
